// File: rtl/outer_product_engine_pkg.sv
// Shared constants and state type for the clk2-domain outer-product path
// (also used by the FIFO and synchronizer stages).
package outer_product_engine_pkg;

   localparam int DATA_W = 4;
   localparam int N      = 16;
   localparam int OUT_W  = 2 * DATA_W;

   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

   localparam int CNT_W = idx_width(N);
   localparam int IDX_W = 2 * CNT_W;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

endpackage

// File: rtl/outer_product_engine_if.sv
// Input pair handshake plus FIFO write port of the outer-product engine.
interface outer_product_engine_if;
   import outer_product_engine_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              fifo_full;
   logic              busy;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;

   modport master (
      output in_valid, in_a, in_b, fifo_full,
      input  busy, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, fifo_full,
      output busy, out_valid, out_data
   );

endinterface

// File: rtl/outer_product_engine.sv
// Collects N (A,B) pairs, then streams the N*N outer product row-major
// into the async FIFO, stalling on fifo_full without losing words.
module outer_product_engine
   import outer_product_engine_pkg::*;
(
   input logic                    clk,
   input logic                    rst_n,
   outer_product_engine_if.slave  bus
);

   state_e            state_r;
   state_e            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [IDX_W-1:0]  idx_r;
   logic [DATA_W-1:0] a_mem_r [N];
   logic [DATA_W-1:0] b_mem_r [N];

   logic [DATA_W-1:0] a_sel_s;
   logic [DATA_W-1:0] b_sel_s;
   logic              busy_s;
   logic              out_valid_s;
   logic [OUT_W-1:0]  out_data_s;

   // Row index comes from the upper idx bits, column from the lower ones
   assign a_sel_s = a_mem_r[idx_r[IDX_W-1:CNT_W]];
   assign b_sel_s = b_mem_r[idx_r[CNT_W-1:0]];

   // Next-state decode and FIFO write outputs
   always_comb begin
      state_nxt_s = state_r;
      busy_s      = 1'b0;
      out_valid_s = 1'b0;
      out_data_s  = {OUT_W{1'b0}};
      case (state_r)
         COLLECT: begin
            if (bus.in_valid && (cnt_r == {CNT_W{1'b1}})) begin
               state_nxt_s = EMIT;
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         EMIT: begin
            busy_s = 1'b1;
            if (!bus.fifo_full) begin
               out_valid_s = 1'b1;
               out_data_s  = OUT_W'(a_sel_s) * OUT_W'(b_sel_s);
               if (idx_r == {IDX_W{1'b1}}) begin
                  state_nxt_s = COLLECT;
               end else begin
                  state_nxt_s = EMIT;
               end
            end else begin
               state_nxt_s = EMIT;
            end
         end
         default: begin
            state_nxt_s = COLLECT;
         end
      endcase
   end

   assign bus.busy      = busy_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = out_data_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Pair capture and read-index counters; both wrap naturally to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
         for (int i = 0; i < N; i++) begin
            a_mem_r[i] <= {DATA_W{1'b0}};
            b_mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if ((state_r == COLLECT) && bus.in_valid) begin
            a_mem_r[cnt_r] <= bus.in_a;
            b_mem_r[cnt_r] <= bus.in_b;
            cnt_r          <= cnt_r + CNT_W'(1'b1);
         end
         if (out_valid_s) begin
            idx_r <= idx_r + IDX_W'(1'b1);
         end
      end
   end

endmodule

// File: tb/tb_outer_product_engine.sv
// Directed bench for outer_product_engine: collect/emit patterns with
// hand-computed spot values and a row-major product model.
module tb_outer_product_engine;
   import outer_product_engine_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   outer_product_engine_if bus();

   outer_product_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors    = 0;
   int          miscompares = 0;
   logic [3:0]  pat_a [16];
   logic [3:0]  pat_b [16];
   logic [7:0]  got   [256];
   int          cycles;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_ov"},   32'(bus.out_valid), 32'd0);
      check({tag, "_data"}, 32'(bus.out_data), 32'd0);
   endtask

   task automatic rand_pattern();
      for (int k = 0; k < 16; k++) begin
         pat_a[k] = 4'($urandom_range(0, 15));
         pat_b[k] = 4'($urandom_range(0, 15));
      end
   endtask

   // Deliver the 16 pairs; gap idle cycles between pulses, none after the last
   task automatic collect(input int gap);
      bus.fifo_full = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = pat_a[k];
         bus.in_b     = pat_b[k];
         #1;
         check("busy_col", 32'(bus.busy), 32'd0);
         check("ov_col",   32'(bus.out_valid), 32'd0);
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (k < 15) repeat (gap) @(negedge clk);
      end
   endtask

   // Drain until stop_at words were written, checking each against the model
   task automatic emit(input bit rand_full, input bit inject, input int stop_at, output int ncyc);
      int e;
      int exp_w;
      e    = 0;
      ncyc = 0;
      while (e < stop_at && ncyc < 4000) begin
         bus.fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
         if (inject) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'($urandom_range(0, 15));
            bus.in_b     = 4'($urandom_range(0, 15));
         end
         #1;
         if (ncyc == 0 && !rand_full) check("first_lat", 32'(bus.out_valid), 32'd1);
         check("busy_emit",  32'(bus.busy), 32'd1);
         check("ov_vs_full", 32'(bus.out_valid), 32'(!bus.fifo_full));
         if (bus.out_valid) begin
            exp_w = int'(pat_a[e / 16]) * int'(pat_b[e % 16]);
            check("word", 32'(bus.out_data), 32'(exp_w));
            got[e] = bus.out_data;
            e++;
         end else begin
            check("zero_idle", 32'(bus.out_data), 32'd0);
         end
         ncyc++;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.fifo_full = 1'b0;
      if (e < stop_at) check("emit_timeout", 32'(e), 32'(stop_at));
      if (stop_at == 256) begin
         #1;
         idle_outputs("post_emit");
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 4'd0;
      bus.in_b      = 4'd0;
      bus.fifo_full = 1'b0;

      // 1: reset with no stimulus
      repeat (2) @(negedge clk);
      idle_outputs("in_reset");
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         idle_outputs("idle");
         @(negedge clk);
      end

      // 2: ramp patterns back-to-back
      for (int k = 0; k < 16; k++) begin
         pat_a[k] = 4'(k);
         pat_b[k] = 4'(15 - k);
      end
      collect(0);
      emit(1'b0, 1'b0, 256, cycles);
      check("t2_cycles", 32'(cycles), 32'd256);
      check("t2_w0",   32'(got[0]),   32'd0);
      check("t2_w17",  32'(got[17]),  32'd14);
      check("t2_w255", 32'(got[255]), 32'd0);
      check("t2_w255r", 32'(got[240]), 32'd225);

      // 3: all-max operands, pulses 3 cycles apart
      for (int k = 0; k < 16; k++) begin
         pat_a[k] = 4'd15;
         pat_b[k] = 4'd15;
      end
      collect(2);
      emit(1'b0, 1'b0, 256, cycles);
      check("t3_cycles", 32'(cycles), 32'd256);
      check("t3_w0",   32'(got[0]),   32'd225);
      check("t3_w255", 32'(got[255]), 32'd225);

      // 4: random operands under random backpressure
      rand_pattern();
      collect(1);
      emit(1'b1, 1'b0, 256, cycles);

      // 5: in_valid held high through EMIT, then a clean pattern
      rand_pattern();
      collect(0);
      emit(1'b0, 1'b1, 256, cycles);
      check("t5_cycles", 32'(cycles), 32'd256);
      rand_pattern();
      collect(0);
      emit(1'b0, 1'b0, 256, cycles);

      // 6: reset after 100 writes, then a full pattern
      rand_pattern();
      collect(0);
      emit(1'b0, 1'b0, 100, cycles);
      #2;
      rst_n = 1'b0;
      #1;
      idle_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      idle_outputs("after_rst");
      @(negedge clk);
      rand_pattern();
      collect(0);
      emit(1'b0, 1'b0, 256, cycles);
      check("t6_w0", 32'(got[0]), 32'(int'(pat_a[0]) * int'(pat_b[0])));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
